// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: states, opcodes, mux and ALU codes.
// No logic here; latency and backpressure are properties of the modules that import it.
// Opcode helpers are pure functions of IR[31:26].
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXE    = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXE    = 4'd11,
        S_I_WB     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || is_itype(op);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: combinational control-word decode from the current FSM state.
// Latency: zero cycles (pure combinational); only mem_ready and zero qualify a state's outputs.
// Backpressure: mem_ready gates the FETCH register loads; wait states are held by mc_ctrl.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        iord,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_we,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal
);

    always_comb begin
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            // Branch target computed here so BRANCH only needs the compare.
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                illegal   = !is_legal(op);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we     = (op == OP_BEQ) ? zero : !zero;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
            end
            S_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ITYPE;
            end
            S_I_WB: begin
                reg_we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose: multi-cycle CPU control FSM (state register + next-state), outputs via ctrl_decode.
// Latency: FETCH-to-FETCH lw 5, sw/R/I 4, branch/jump 3 cycles with memory ready.
// Backpressure: FETCH, MEM_RD and MEM_WR hold one extra cycle per mem_ready=0 cycle.
module mc_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        iord,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_we,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((op == OP_LW) || (op == OP_SW))        state_d = S_MEM_ADDR;
                else if (op == OP_RTYPE)                   state_d = S_R_EXE;
                else if ((op == OP_BEQ) || (op == OP_BNE)) state_d = S_BRANCH;
                else if (op == OP_J)                       state_d = S_JUMP;
                else if (is_itype(op))                     state_d = S_I_EXE;
                else                                       state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXE:    state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_I_EXE:    state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            // Encodings 13-15 fall through here and recover via INIT.
            default:    state_d = S_INIT;
        endcase
    end

    assign state = state_q;

    ctrl_decode u_decode (
        .state      (state_q),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction table, hand-written corner sequences,
// and random instructions with random memory stalls against a state-path reference model.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         lat;
        int         n_reg_we;
        int         n_pc_we;
        int         n_illegal;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int exp_path[$];
    int seen_q[$];
    int r_cycles, r_reg_we, r_pc_we, r_illegal, r_memrd_wait;

    function automatic out_t dut_out();
        return '{pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_src, illegal};
    endfunction

    function automatic logic legal_op(input logic [5:0] o);
        logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e};
        foreach (ops[i]) if (ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: the ordered list of states an instruction visits, by opcode class.
    function automatic void build_path(input logic [5:0] o);
        exp_path = '{1, 2};
        if (o == 6'h23)                    exp_path = {exp_path, 3, 4, 5};
        else if (o == 6'h2b)               exp_path = {exp_path, 3, 6};
        else if (o == 6'h00)               exp_path = {exp_path, 7, 8};
        else if (o == 6'h04 || o == 6'h05) exp_path = {exp_path, 9};
        else if (o == 6'h02)               exp_path = {exp_path, 10};
        else if (legal_op(o))              exp_path = {exp_path, 11, 12};
    endfunction

    // Reference: control word required in each state, straight from the state table.
    function automatic out_t exp_out(input int st, input logic [5:0] o, input logic z,
                                     input logic mr);
        out_t e = '0;
        case (st)
            1:  begin e.mem_rd = 1; e.alu_src_b = 2'd1; e.ir_we = mr; e.pc_we = mr; end
            2:  begin e.alu_src_b = 2'd3; e.illegal = !legal_op(o); end
            3:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
            4:  begin e.mem_rd = 1; e.iord = 1; end
            5:  begin e.reg_we = 1; e.mem_to_reg = 1; end
            6:  begin e.mem_wr = 1; e.iord = 1; end
            7:  begin e.alu_src_a = 1; e.alu_op = 2'd2; end
            8:  begin e.reg_we = 1; e.reg_dst = 1; end
            9:  begin e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_src = 2'd1;
                      e.pc_we = (o == 6'h04) ? z : !z; end
            10: begin e.pc_src = 2'd2; e.pc_we = 1; end
            11: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 2'd3; end
            12: begin e.reg_we = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Runs one instruction starting with the DUT in FETCH; checks every cycle.
    task automatic run_instr(input logic [5:0] o, input logic z, input int stall_pct,
                             input int stall_st, input int stall_n);
        int idx = 0;
        int left = stall_n;
        int cur;
        build_path(o);
        seen_q = {};
        r_cycles = 0; r_reg_we = 0; r_pc_we = 0; r_illegal = 0; r_memrd_wait = 0;
        while (idx < exp_path.size()) begin
            @(negedge clk);
            op = o;
            zero = z;
            cur = exp_path[idx];
            if (cur == stall_st && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = ($urandom_range(99) >= stall_pct);
            end
            #1;
            seen_q.push_back(int'(state));
            chk("state", int'(state), cur);
            chk("outputs", int'(dut_out()), int'(exp_out(cur, o, z, mem_ready)));
            r_reg_we  += int'(reg_we);
            r_pc_we   += int'(pc_we);
            r_illegal += int'(illegal);
            if (state == 4'd4 && !mem_ready && mem_rd && iord) r_memrd_wait++;
            if (!((cur == 1 || cur == 4 || cur == 6) && !mem_ready)) idx++;
            r_cycles++;
            if (r_cycles > 100) begin
                chk("cycle_budget", r_cycles, 100);
                break;
            end
        end
    endtask

    vec_t vecs [12];
    logic [5:0] rand_ops [13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08,
                                  6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h3f, 6'h01};

    initial begin
        vecs[0]  = '{op: 6'h23, zero: 0, lat: 5, n_reg_we: 1, n_pc_we: 1, n_illegal: 0};
        vecs[1]  = '{op: 6'h2b, zero: 0, lat: 4, n_reg_we: 0, n_pc_we: 1, n_illegal: 0};
        vecs[2]  = '{op: 6'h00, zero: 1, lat: 4, n_reg_we: 1, n_pc_we: 1, n_illegal: 0};
        vecs[3]  = '{op: 6'h08, zero: 0, lat: 4, n_reg_we: 1, n_pc_we: 1, n_illegal: 0};
        vecs[4]  = '{op: 6'h0e, zero: 1, lat: 4, n_reg_we: 1, n_pc_we: 1, n_illegal: 0};
        vecs[5]  = '{op: 6'h04, zero: 1, lat: 3, n_reg_we: 0, n_pc_we: 2, n_illegal: 0};
        vecs[6]  = '{op: 6'h04, zero: 0, lat: 3, n_reg_we: 0, n_pc_we: 1, n_illegal: 0};
        vecs[7]  = '{op: 6'h05, zero: 1, lat: 3, n_reg_we: 0, n_pc_we: 1, n_illegal: 0};
        vecs[8]  = '{op: 6'h05, zero: 0, lat: 3, n_reg_we: 0, n_pc_we: 2, n_illegal: 0};
        vecs[9]  = '{op: 6'h02, zero: 0, lat: 3, n_reg_we: 0, n_pc_we: 2, n_illegal: 0};
        vecs[10] = '{op: 6'h3f, zero: 0, lat: 2, n_reg_we: 0, n_pc_we: 1, n_illegal: 1};
        vecs[11] = '{op: 6'h01, zero: 1, lat: 2, n_reg_we: 0, n_pc_we: 1, n_illegal: 1};

        op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'(dut_out()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_outputs", int'(dut_out()), 0);
        @(posedge clk); #1;
        chk("first_edge_fetch", int'(state), 1);

        // R-type walk: 1,2,7,8 then back to FETCH.
        run_instr(6'h00, 1'b0, 0, 0, 0);
        chk("rtype_len", seen_q.size(), 4);
        if (seen_q.size() == 4) begin
            chk("rtype_seq2", seen_q[1], 2);
            chk("rtype_seq3", seen_q[2], 7);
            chk("rtype_seq4", seen_q[3], 8);
        end

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].zero, 0, 0, 0);
            chk($sformatf("lat_op%02h", vecs[i].op), r_cycles, vecs[i].lat);
            chk($sformatf("reg_we_op%02h", vecs[i].op), r_reg_we, vecs[i].n_reg_we);
            chk($sformatf("pc_we_op%02h_z%0d", vecs[i].op, vecs[i].zero), r_pc_we, vecs[i].n_pc_we);
            chk($sformatf("illegal_op%02h", vecs[i].op), r_illegal, vecs[i].n_illegal);
        end

        // lw with three memory wait cycles in MEM_RD.
        run_instr(6'h23, 1'b0, 0, 4, 3);
        chk("lw_wait_latency", r_cycles, 8);
        chk("lw_wait_memrd_held", r_memrd_wait, 3);
        chk("lw_wait_reg_we", r_reg_we, 1);

        // Asynchronous reset in the middle of a stalled MEM_WR.
        @(negedge clk); op = 6'h2b; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        chk("sw_in_mem_wr", int'(state), 6);
        chk("sw_mem_wr_high", int'(mem_wr), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_mem_wr", int'(mem_wr), 0);
        chk("async_rst_outputs", int'(dut_out()), 0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_fetch", int'(state), 1);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] o;
            o = rand_ops[$urandom_range(12)];
            if ($urandom_range(9) == 0) o = 6'($urandom());
            run_instr(o, 1'($urandom()), 30, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  CPU clock from the divider; every state change on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 op  input  6  opcode, IR[31:26], held stable by the IR outside FETCH.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 mem_ready  input  1  memory handshake, 1 = current access completes this cycle.
REQ-006 pc_we  output  1  PC load enable.
REQ-007 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 mem_rd  output  1  memory read request.
REQ-009 mem_wr  output  1  memory write request.
REQ-010 ir_we  output  1  IR load enable; the MDR loads every cycle.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
REQ-013 mem_to_reg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
REQ-014 alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register.
REQ-015 alu_src_b  output  2  ALU B select: 00 = B register, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
REQ-016 alu_op  output  2  ALUcontrol code: 00 = add, 01 = sub, 10 = funct, 11 = I-type.
REQ-017 pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-019 state  output  4  current state, for debug.

Function
REQ-020 The block SHALL be a Moore FSM with a registered state; outputs SHALL be decoded from state only, except for the mem_ready and zero qualifiers stated below; every output not listed for a state SHALL be 0.
REQ-021 State encodings SHALL be: INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXE=7, R_WB=8, BRANCH=9, JUMP=10, I_EXE=11, I_WB=12.
REQ-022 INIT SHALL drive all outputs 0 and SHALL go unconditionally to FETCH.
REQ-023 FETCH SHALL drive mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-024 In FETCH, ir_we and pc_we SHALL equal mem_ready; the FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-025 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, which precomputes the branch target.
REQ-026 DECODE SHALL go to:
- MEM_ADDR for op 100011 (lw) or 101011 (sw);
- R_EXE for op 000000;
- BRANCH for op 000100 (beq) or 000101 (bne);
- JUMP for op 000010;
- I_EXE for op 001000, 001010, 001100, 001101 or 001110.
REQ-027 For any other opcode, DECODE SHALL pulse illegal=1 and go to FETCH.
REQ-028 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, and SHALL go to MEM_RD for lw or MEM_WR for sw.
REQ-029 MEM_RD SHALL drive mem_rd=1, iord=1, SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-030 MEM_WB SHALL drive reg_we=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-031 MEM_WR SHALL drive mem_wr=1, iord=1, SHALL hold until mem_ready=1, then go to FETCH.
REQ-032 R_EXE SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
REQ-033 R_WB SHALL drive reg_we=1, reg_dst=1, then go to FETCH.
REQ-034 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, then go to FETCH.
REQ-035 In BRANCH, pc_we SHALL be zero for beq and !zero for bne.
REQ-036 JUMP SHALL drive pc_src=10, pc_we=1, then go to FETCH.
REQ-037 I_EXE SHALL drive alu_src_a=1, alu_src_b=10, alu_op=11, then go to I_WB.
REQ-038 I_WB SHALL drive reg_we=1, reg_dst=0, then go to FETCH.
REQ-039 With mem_ready held at 1, latency in cycles FETCH-to-FETCH SHALL be: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3.
REQ-040 Each memory wait SHALL add exactly one cycle per mem_ready=0 cycle.
REQ-041 mem_rd and mem_wr SHALL never both be 1 in the same cycle.
REQ-042 Unused state encodings 13-15 SHALL go to INIT on the next clock edge, with all outputs 0 while in them.

Reset
REQ-043 rst_n=0 SHALL force state=INIT immediately, asynchronously, in any state including mid-wait; all outputs SHALL then be 0.
REQ-044 After rst_n deasserts, the first rising edge SHALL move INIT to FETCH; no register or memory write SHALL occur before FETCH.

Structure
REQ-045 A shared package ctrl_pkg SHALL hold the state encodings, opcode constants, and the alu_op, alu_src_b and pc_src codes.
REQ-046 The output decode SHALL be one combinational sub-module, ctrl_decode (inputs state, op, zero, mem_ready); the state register and next-state logic SHALL stay in mc_ctrl.

Verification
REQ-047 Reset, then mem_ready=1, op=000000 → state sequence 0,1,2,7,8,1; reg_we=1 with reg_dst=1 in state 8 only.
REQ-048 op=100011, mem_ready=0 for 3 cycles in MEM_RD → 8 cycles FETCH-to-FETCH; mem_rd and iord held at 1 throughout the wait; reg_we=1 with mem_to_reg=1 once.
REQ-049 op=000100 with zero=1 → pc_we=1, pc_src=01 in BRANCH; op=000101 with zero=1 → pc_we=0.
REQ-050 op=001101 → state 11 with alu_op=11, alu_src_b=10, then state 12 with reg_we=1, reg_dst=0.
REQ-051 op=111111 → illegal=1 for one cycle in DECODE, then state 1; no write enable asserted.
REQ-052 rst_n pulsed low during MEM_WR with mem_ready=0 → state=0 and mem_wr=0 within the same cycle, before any clock edge; FETCH follows the first edge after release.
